// File: rtl/router_pkt_tx.sv
// Router input-port packet transmitter: stages payload bytes in a 64x8 buffer and
// streams header, payload and parity to the router under busy back-pressure.
module router_pkt_tx #(
    parameter int GAP = 2
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       start,
    input  logic [1:0] addr,
    input  logic [5:0] len,
    input  logic       busy,
    output logic [7:0] data_out,
    output logic       pkt_valid,
    output logic       tx_busy,
    output logic       done,
    output logic       err
);
    localparam logic [3:0] GAP_W = 4'(GAP);

    typedef enum logic [2:0] {IDLE, HEADER, PAYLOAD, PARITY, GAP_WAIT} state_t;

    state_t     state, state_n;
    logic [7:0] mem [64];
    logic [5:0] wr_ptr, wr_ptr_n, rd_ptr, rd_ptr_n, len_q, len_n;
    logic [1:0] addr_q, addr_n;
    logic [7:0] parity, parity_n, data_n;
    logic [3:0] gap_cnt, gap_cnt_n;
    logic       done_n, err_n, wr_fire, bad_start;

    always_comb begin
        state_n   = state;
        wr_ptr_n  = wr_ptr;
        rd_ptr_n  = rd_ptr;
        len_n     = len_q;
        addr_n    = addr_q;
        parity_n  = parity;
        gap_cnt_n = gap_cnt;
        done_n    = 1'b0;
        err_n     = 1'b0;
        wr_fire   = 1'b0;
        // Validation uses the pre-write pointer even when a write lands in the same cycle.
        bad_start = (len == 6'd0) || (addr == 2'd3) || (len > wr_ptr);
        case (state)
            IDLE: begin
                if (wr_en && wr_ptr != 6'd63) begin
                    wr_fire  = 1'b1;
                    wr_ptr_n = wr_ptr + 6'd1;
                end
                if (start) begin
                    if (bad_start) begin
                        err_n = 1'b1;
                    end else begin
                        state_n  = HEADER;
                        addr_n   = addr;
                        len_n    = len;
                        parity_n = {len, addr};
                    end
                end
            end
            HEADER: begin
                if (!busy) begin
                    state_n  = PAYLOAD;
                    rd_ptr_n = 6'd0;
                end
            end
            PAYLOAD: begin
                if (!busy) begin
                    parity_n = parity ^ mem[rd_ptr];
                    if (rd_ptr == len_q - 6'd1) state_n = PARITY;
                    else rd_ptr_n = rd_ptr + 6'd1;
                end
            end
            PARITY: begin
                if (!busy) begin
                    done_n    = 1'b1;
                    wr_ptr_n  = 6'd0;
                    rd_ptr_n  = 6'd0;
                    gap_cnt_n = GAP_W;
                    state_n   = (GAP_W == 4'd0) ? IDLE : GAP_WAIT;
                end
            end
            GAP_WAIT: begin
                if (gap_cnt <= 4'd1) begin
                    state_n   = IDLE;
                    gap_cnt_n = 4'd0;
                end else begin
                    gap_cnt_n = gap_cnt - 4'd1;
                end
            end
            default: state_n = IDLE;
        endcase

        // Outputs are registered, so they follow the state being entered.
        case (state_n)
            HEADER:  data_n = {len_n, addr_n};
            PAYLOAD: data_n = mem[rd_ptr_n];
            PARITY:  data_n = parity_n;
            default: data_n = 8'h00;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            wr_ptr    <= 6'd0;
            rd_ptr    <= 6'd0;
            len_q     <= 6'd0;
            addr_q    <= 2'd0;
            parity    <= 8'h00;
            gap_cnt   <= 4'd0;
            data_out  <= 8'h00;
            pkt_valid <= 1'b0;
            tx_busy   <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            wr_ptr    <= wr_ptr_n;
            rd_ptr    <= rd_ptr_n;
            len_q     <= len_n;
            addr_q    <= addr_n;
            parity    <= parity_n;
            gap_cnt   <= gap_cnt_n;
            data_out  <= data_n;
            pkt_valid <= (state_n == HEADER) || (state_n == PAYLOAD);
            tx_busy   <= (state_n != IDLE);
            done      <= done_n;
            err       <= err_n;
        end
    end

    // Buffer contents survive reset; only the pointers are cleared.
    always_ff @(posedge clock) begin
        if (wr_fire) mem[wr_ptr] <= wr_data;
    end
endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed bench for router_pkt_tx: basic, back-pressure, rejects, max length,
// reset mid-payload and back-to-back start handling.
module tb_router_pkt_tx;
    logic       clock = 1'b0;
    logic       resetn;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       start;
    logic [1:0] addr;
    logic [5:0] len;
    logic       busy;
    logic [7:0] data_out;
    logic       pkt_valid, tx_busy, done, err;

    int checks   = 0;
    int failures = 0;

    router_pkt_tx #(.GAP(2)) dut (
        .clock(clock), .resetn(resetn), .wr_en(wr_en), .wr_data(wr_data),
        .start(start), .addr(addr), .len(len), .busy(busy),
        .data_out(data_out), .pkt_valid(pkt_valid), .tx_busy(tx_busy),
        .done(done), .err(err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic go(input logic [1:0] a, input logic [5:0] l);
        start = 1'b1;
        addr  = a;
        len   = l;
        tick();
        start = 1'b0;
    endtask

    task automatic bus(input string tag, input logic [7:0] d, input logic v);
        chk({tag, "_data"}, data_out, d);
        chk({tag, "_vld"}, pkt_valid, v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; wr_en = 1'b0; wr_data = 8'h00; start = 1'b0;
        addr = 2'd0; len = 6'd0; busy = 1'b0;
        tick(); tick();
        chk("rst_data", data_out, 8'h00);
        chk("rst_vld", pkt_valid, 1'b0);
        chk("rst_txb", tx_busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        resetn = 1'b1;
        tick();

        // Basic packet, then start during GAP_WAIT (ignored) and at done+3 (honoured)
        wr(8'h11); wr(8'h22); wr(8'h33);
        go(2'd1, 6'd3);
        bus("b_hdr", 8'h0D, 1'b1);
        chk("b_txb", tx_busy, 1'b1);
        tick(); bus("b_p0", 8'h11, 1'b1);
        tick(); bus("b_p1", 8'h22, 1'b1);
        tick(); bus("b_p2", 8'h33, 1'b1);
        tick(); bus("b_par", 8'h0D, 1'b0);
        chk("b_done_early", done, 1'b0);
        tick();
        chk("b_done", done, 1'b1);
        chk("b_done_txb", tx_busy, 1'b1);
        bus("b_gap", 8'h00, 1'b0);
        start = 1'b1; addr = 2'd1; len = 6'd1;
        tick();
        chk("b_done_once", done, 1'b0);
        chk("b2b_ign_err1", err, 1'b0);
        chk("b_gap_txb", tx_busy, 1'b1);
        tick();
        chk("b2b_ign_err2", err, 1'b0);
        chk("b_idle_txb", tx_busy, 1'b0);
        tick();
        chk("b2b_honour_err", err, 1'b1);
        chk("b2b_txb", tx_busy, 1'b0);
        start = 1'b0;
        tick();
        chk("b2b_err_pulse", err, 1'b0);

        // Back-pressure
        wr(8'h11); wr(8'h22); wr(8'h33);
        go(2'd1, 6'd3);
        busy = 1'b1;
        bus("bp_hdr", 8'h0D, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick(); bus("bp_hdr_hold", 8'h0D, 1'b1);
        end
        busy = 1'b0;
        tick(); bus("bp_p0", 8'h11, 1'b1);
        tick(); bus("bp_p1", 8'h22, 1'b1);
        busy = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick(); bus("bp_p1_hold", 8'h22, 1'b1);
        end
        busy = 1'b0;
        tick(); bus("bp_p2", 8'h33, 1'b1);
        tick(); bus("bp_par", 8'h0D, 1'b0);
        tick(); chk("bp_done", done, 1'b1);
        tick(); tick();
        chk("bp_idle", tx_busy, 1'b0);

        // Rejects, then a valid 4-byte packet
        wr(8'hA1); wr(8'hB2); wr(8'hC3); wr(8'hD4);
        go(2'd0, 6'd0);
        chk("rj_len0_err", err, 1'b1);
        chk("rj_len0_txb", tx_busy, 1'b0);
        tick(); chk("rj_len0_pulse", err, 1'b0);
        go(2'd3, 6'd1);
        chk("rj_addr3_err", err, 1'b1);
        chk("rj_addr3_txb", tx_busy, 1'b0);
        tick();
        go(2'd0, 6'd5);
        chk("rj_len5_err", err, 1'b1);
        chk("rj_len5_txb", tx_busy, 1'b0);
        tick();
        go(2'd0, 6'd4);
        chk("ok4_err", err, 1'b0);
        bus("ok4_hdr", 8'h10, 1'b1);
        tick(); bus("ok4_p0", 8'hA1, 1'b1);
        tick(); bus("ok4_p1", 8'hB2, 1'b1);
        tick(); bus("ok4_p2", 8'hC3, 1'b1);
        tick(); bus("ok4_p3", 8'hD4, 1'b1);
        tick(); bus("ok4_par", 8'h14, 1'b0);
        tick(); chk("ok4_done", done, 1'b1);
        tick(); tick();

        // Max length with a dropped 64th write
        for (int i = 0; i < 63; i++) wr(8'(i));
        wr(8'hFF);
        go(2'd2, 6'd63);
        bus("max_hdr", 8'hFE, 1'b1);
        for (int i = 0; i < 63; i++) begin
            tick(); bus("max_pay", 8'(i), 1'b1);
        end
        tick(); bus("max_par", 8'hC1, 1'b0);
        tick(); chk("max_done", done, 1'b1);
        tick(); tick();

        // Reset mid-payload
        wr(8'h11); wr(8'h22); wr(8'h33);
        go(2'd1, 6'd3);
        tick(); tick();
        bus("rm_p1", 8'h22, 1'b1);
        resetn = 1'b0;
        #1;
        bus("rm_async", 8'h00, 1'b0);
        chk("rm_async_txb", tx_busy, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick(); chk("rm_no_done", done, 1'b0);
        end
        resetn = 1'b1;
        tick();
        chk("rm_after_done", done, 1'b0);
        go(2'd0, 6'd1);
        chk("rm_empty_err", err, 1'b1);
        chk("rm_empty_txb", tx_busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
